// File: rtl/ofmap_gb_pkg.sv
// Shared types and helpers for the ofmap global-buffer controller.
// Holds the drain FSM encoding and the beat-count divider.
package ofmap_gb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_READ,
      S_TAIL,
      S_FIN
   } drain_state_e;

   function automatic int unsigned ceil_div(
      input int unsigned n,
      input int unsigned d
   );
      return (n + d - 1) / d;
   endfunction

endpackage

// File: rtl/ofmap_gb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr with wrap,
// plus the pointer to use after that grant.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] ptr_nxt_o
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt_o     = '0;
      ptr_nxt_o = ptr_i;
      found     = 1'b0;
      idx       = '0;
      for (int off = 0; off < N; off++) begin
         idx = PW'((int'(ptr_i) + off) % N);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            ptr_nxt_o  = PW'((int'(idx) + 1) % N);
         end
      end
   end

endmodule

// File: rtl/ofmap_gb_ctrl.sv
// Ofmap GB controller: round-robin write arbitration onto the single
// write port and a drain sequencer streaming X_dim-word beats out.
module ofmap_gb_ctrl
   import ofmap_gb_pkg::*;
#(
   parameter int DATA_BITWIDTH = 16,
   parameter int ADDR_BITWIDTH = 10,
   parameter int X_dim         = 3,
   parameter int NUM_REQ       = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               wr_valid,
   input  logic [NUM_REQ*ADDR_BITWIDTH-1:0] wr_addr,
   input  logic [NUM_REQ*DATA_BITWIDTH-1:0] wr_data,
   output logic [NUM_REQ-1:0]               wr_ready,
   output logic                             gb_write_en,
   output logic [ADDR_BITWIDTH-1:0]         gb_w_addr,
   output logic [DATA_BITWIDTH-1:0]         gb_w_data,
   input  logic                             drain_start,
   input  logic [ADDR_BITWIDTH-1:0]         drain_base,
   input  logic [ADDR_BITWIDTH:0]           drain_count,
   output logic                             drain_busy,
   output logic                             gb_read_req_inter,
   output logic [ADDR_BITWIDTH-1:0]         gb_r_addr_inter,
   input  logic                             gb_read_en_inter,
   input  logic [DATA_BITWIDTH*X_dim-1:0]   gb_r_data_inter,
   output logic                             out_valid,
   output logic [DATA_BITWIDTH*X_dim-1:0]   out_data,
   output logic [ADDR_BITWIDTH-1:0]         out_beat,
   output logic                             drain_done
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = ADDR_BITWIDTH + 1;
   localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_BITWIDTH{1'b0}}};
   localparam logic [ADDR_BITWIDTH-1:0] X_A = ADDR_BITWIDTH'(X_dim);

   drain_state_e state_q, state_d;

   logic [PW-1:0]            rr_ptr_q;
   logic [PW-1:0]            ptr_nxt;
   logic [NUM_REQ-1:0]       gnt;
   logic                     arb_en;

   logic                     we_q;
   logic [ADDR_BITWIDTH-1:0] waddr_q;
   logic [DATA_BITWIDTH-1:0] wdata_q;
   logic [ADDR_BITWIDTH-1:0] sel_addr;
   logic [DATA_BITWIDTH-1:0] sel_data;

   logic [ADDR_BITWIDTH-1:0] ptr_q, ptr_d;
   logic [CW-1:0]            beats_q, beats_d;
   logic [CW-1:0]            k_q, k_d;
   logic                     req_q, req_d;
   logic [ADDR_BITWIDTH-1:0] raddr_q, raddr_d;
   logic                     done_q, done_d;
   logic [ADDR_BITWIDTH-1:0] beat_q;

   logic [CW-1:0]            cnt_c;
   logic [CW-1:0]            beats_w;
   logic                     start_ok;

   // Writes only flow while idle, so a drain never observes a torn region.
   assign arb_en   = (state_q == S_IDLE) && !drain_start;
   assign start_ok = (state_q == S_IDLE) && drain_start;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_arb (
      .req_i     (wr_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .ptr_nxt_o (ptr_nxt)
   );

   assign wr_ready = arb_en ? gnt : '0;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wr_ready[i]) begin
            sel_addr = wr_addr[i*ADDR_BITWIDTH +: ADDR_BITWIDTH];
            sel_data = wr_data[i*DATA_BITWIDTH +: DATA_BITWIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         we_q <= |wr_ready;
         if (|wr_ready) begin
            rr_ptr_q <= ptr_nxt;
            waddr_q  <= sel_addr;
            wdata_q  <= sel_data;
         end
      end
   end

   assign cnt_c   = (drain_count > DEPTH) ? DEPTH : drain_count;
   assign beats_w = CW'(ceil_div(32'(cnt_c), 32'(X_dim)));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      beats_d = beats_q;
      k_d     = k_q;
      req_d   = 1'b0;
      raddr_d = raddr_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (drain_start) begin
               ptr_d   = drain_base;
               beats_d = beats_w;
               k_d     = '0;
               state_d = (beats_w == '0) ? S_FIN : S_FLUSH;
            end
         end
         S_FLUSH: state_d = S_READ;
         S_READ: begin
            req_d   = 1'b1;
            raddr_d = ptr_q;
            ptr_d   = ptr_q + X_A;
            k_d     = k_q + 1'b1;
            if (k_d == beats_q) state_d = S_TAIL;
         end
         S_TAIL: state_d = S_FIN;
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         beats_q <= '0;
         k_q     <= '0;
         req_q   <= 1'b0;
         raddr_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         beats_q <= beats_d;
         k_q     <= k_d;
         req_q   <= req_d;
         raddr_q <= raddr_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_q <= '0;
      end else if (start_ok) begin
         beat_q <= '0;
      end else if (gb_read_en_inter) begin
         beat_q <= beat_q + 1'b1;
      end
   end

   assign gb_write_en       = we_q;
   assign gb_w_addr         = waddr_q;
   assign gb_w_data         = wdata_q;
   assign drain_busy        = (state_q != S_IDLE);
   assign gb_read_req_inter = req_q;
   assign gb_r_addr_inter   = raddr_q;
   assign out_valid         = gb_read_en_inter;
   assign out_data          = gb_r_data_inter;
   assign out_beat          = beat_q;
   assign drain_done        = done_q;

endmodule

// File: tb/tb_ofmap_gb_ctrl.sv
// Directed bench for ofmap_gb_ctrl with a small behavioural GB model.
module tb_ofmap_gb_ctrl;

   localparam int DW = 16;
   localparam int AW = 10;
   localparam int XD = 3;
   localparam int NR = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     wr_valid;
   logic [NR*AW-1:0]  wr_addr;
   logic [NR*DW-1:0]  wr_data;
   logic [NR-1:0]     wr_ready;
   logic              gb_write_en;
   logic [AW-1:0]     gb_w_addr;
   logic [DW-1:0]     gb_w_data;
   logic              drain_start;
   logic [AW-1:0]     drain_base;
   logic [AW:0]       drain_count;
   logic              drain_busy;
   logic              gb_read_req_inter;
   logic [AW-1:0]     gb_r_addr_inter;
   logic              gb_read_en_inter = 1'b0;
   logic [DW*XD-1:0]  gb_r_data_inter = '0;
   logic              out_valid;
   logic [DW*XD-1:0]  out_data;
   logic [AW-1:0]     out_beat;
   logic              drain_done;

   int n_cmp = 0;
   int n_err = 0;

   int nreq, nbeat, ndone, first_req_c, done_c, last_beat_c;
   logic [AW-1:0]    exp_addr [4];
   logic [DW*XD-1:0] exp_beat [4];

   logic [DW-1:0] mem [0:1023];

   always #5 clk = ~clk;

   ofmap_gb_ctrl #(
      .DATA_BITWIDTH (DW),
      .ADDR_BITWIDTH (AW),
      .X_dim         (XD),
      .NUM_REQ       (NR)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .wr_valid          (wr_valid),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .wr_ready          (wr_ready),
      .gb_write_en       (gb_write_en),
      .gb_w_addr         (gb_w_addr),
      .gb_w_data         (gb_w_data),
      .drain_start       (drain_start),
      .drain_base        (drain_base),
      .drain_count       (drain_count),
      .drain_busy        (drain_busy),
      .gb_read_req_inter (gb_read_req_inter),
      .gb_r_addr_inter   (gb_r_addr_inter),
      .gb_read_en_inter  (gb_read_en_inter),
      .gb_r_data_inter   (gb_r_data_inter),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_beat          (out_beat),
      .drain_done        (drain_done)
   );

   // GB model: one write port, 1-cycle-latency 3-word read with wrap.
   always @(posedge clk) begin
      if (gb_write_en) mem[gb_w_addr] <= gb_w_data;
      gb_read_en_inter <= gb_read_req_inter;
      if (gb_read_req_inter)
         gb_r_data_inter <= {mem[gb_r_addr_inter + 10'd2],
                             mem[gb_r_addr_inter + 10'd1],
                             mem[gb_r_addr_inter]};
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
      wr_addr[i*AW +: AW] = a;
      wr_data[i*DW +: DW] = d;
   endtask

   task automatic start_drain(input logic [AW-1:0] b, input logic [AW:0] n);
      drain_base  = b;
      drain_count = n;
      drain_start = 1'b1;
      #1;
      if (wr_valid != '0) chk("start_blk", wr_ready, 0);
      tick;
      drain_start = 1'b0;
   endtask

   // c counts cycles after the one in which drain_start was high.
   task automatic watch(input int ncyc, input int inj_c);
      nreq = 0; nbeat = 0; ndone = 0;
      first_req_c = -1; done_c = -1; last_beat_c = -1;
      for (int c = 1; c <= ncyc; c++) begin
         drain_start = (c == inj_c);
         #1;
         if (gb_read_req_inter) begin
            if (nreq == 0) first_req_c = c;
            if (nreq < 4) chk("rd_addr", gb_r_addr_inter, exp_addr[nreq]);
            nreq++;
         end
         if (out_valid) begin
            if (nbeat < 4) begin
               chk("beat_data", out_data, exp_beat[nbeat]);
               chk("beat_idx", out_beat, nbeat);
            end
            last_beat_c = c;
            nbeat++;
         end
         if (drain_done) begin
            done_c = c;
            ndone++;
         end
         if (drain_busy && wr_valid != '0) chk("busy_blk", wr_ready, 0);
         tick;
      end
      drain_start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      reset = 1'b1;
      wr_valid = '0;
      wr_addr = '0;
      wr_data = '0;
      drain_start = 1'b0;
      drain_base = '0;
      drain_count = '0;
      repeat (3) tick;

      chk("rst_we", gb_write_en, 0);
      chk("rst_busy", drain_busy, 0);
      chk("rst_req", gb_read_req_inter, 0);
      chk("rst_done", drain_done, 0);
      chk("rst_beat", out_beat, 0);
      chk("rst_waddr", gb_w_addr, 0);
      reset = 1'b0;
      tick;

      // All requesters hold: grants rotate 0,1,2,3,0.
      for (int i = 0; i < NR; i++) set_wr(i, AW'(i), DW'(16'h100 + i));
      wr_valid = '1;
      for (int g = 0; g < 5; g++) begin
         #1;
         chk("rr_gnt", wr_ready, 1 << (g % 4));
         tick;
         chk("rr_we", gb_write_en, 1);
         chk("rr_waddr", gb_w_addr, g % 4);
         chk("rr_wdata", gb_w_data, 16'h100 + (g % 4));
      end

      // Lone requester 2, then pointer must sit at 3.
      wr_valid = 4'b0100;
      for (int g = 0; g < 3; g++) begin
         #1;
         chk("solo_gnt", wr_ready, 4'b0100);
         tick;
      end
      wr_valid = '1;
      #1;
      chk("ptr3_gnt", wr_ready, 4'b1000);
      tick;
      wr_valid = '0;
      #1;
      chk("idle_rdy", wr_ready, 0);
      tick;
      chk("idle_we", gb_write_en, 0);

      // Fill addr 0..8 with 1..9 through requester 1.
      wr_valid = 4'b0010;
      for (int a = 0; a < 9; a++) begin
         set_wr(1, AW'(a), DW'(a + 1));
         tick;
         chk("fill_waddr", gb_w_addr, a);
      end
      wr_valid = '0;
      tick;

      // Drain 9 words from 0.
      exp_addr[0] = 10'd0; exp_addr[1] = 10'd3;
      exp_addr[2] = 10'd6; exp_addr[3] = 10'd9;
      exp_beat[0] = {16'd3, 16'd2, 16'd1};
      exp_beat[1] = {16'd6, 16'd5, 16'd4};
      exp_beat[2] = {16'd9, 16'd8, 16'd7};
      exp_beat[3] = '0;
      start_drain(10'd0, 11'd9);
      watch(12, 0);
      chk("d9_nreq", nreq, 3);
      chk("d9_nbeat", nbeat, 3);
      chk("d9_ndone", ndone, 1);
      chk("d9_first", first_req_c, 3);
      chk("d9_donelat", done_c - last_beat_c, 1);
      chk("d9_idle", drain_busy, 0);

      // Zero-length drain.
      start_drain(10'd5, 11'd0);
      watch(6, 0);
      chk("d0_nreq", nreq, 0);
      chk("d0_done", done_c, 2);
      chk("d0_ndone", ndone, 1);

      // Wrap at top of memory, plus a start while busy.
      exp_addr[0] = 10'd1023;
      exp_beat[0] = {16'd2, 16'd1, 16'd0};
      start_drain(10'd1023, 11'd3);
      watch(12, 2);
      chk("wr_nreq", nreq, 1);
      chk("wr_ndone", ndone, 1);
      chk("wr_nbeat", nbeat, 1);
      chk("wr_donelat", done_c - last_beat_c, 1);

      // Oversized count clamps to the full depth: 342 beats.
      exp_addr[0] = 10'd0; exp_addr[1] = 10'd3;
      exp_addr[2] = 10'd6; exp_addr[3] = 10'd9;
      exp_beat[0] = {16'd3, 16'd2, 16'd1};
      start_drain(10'd0, 11'h7FF);
      watch(360, 0);
      chk("cl_nreq", nreq, 342);
      chk("cl_nbeat", nbeat, 342);
      chk("cl_ndone", ndone, 1);

      // Writes held through a drain, then reset mid-READ.
      for (int i = 0; i < NR; i++) set_wr(i, AW'(i), DW'(16'h100 + i));
      wr_valid = '1;
      start_drain(10'd0, 11'd9);
      for (int c = 1; c <= 3; c++) begin
         #1;
         chk("hold_blk", wr_ready, 0);
         tick;
      end
      chk("mid_req", gb_read_req_inter, 1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("ab_req", gb_read_req_inter, 0);
      chk("ab_busy", drain_busy, 0);
      chk("ab_done", drain_done, 0);
      chk("ab_we", gb_write_en, 0);
      chk("ab_beat", out_beat, 0);
      chk("ab_gnt", wr_ready, 4'b0001);
      tick;
      watch(8, 0);
      chk("ab_ndone", ndone, 0);
      chk("ab_nreq", nreq, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
